// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues imem word reads,
// and buffers {pc, insn} pairs for decode; branch redirect flushes all.
module fetch_queue #(
  parameter logic [31:0] base_addr = 32'h80020000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic [1:0]  imem_access_size,
  output logic        imem_rw,
  output logic        imem_enable,
  input  logic        imem_busy,
  input  logic [31:0] imem_data,
  input  logic        do_branch,
  input  logic [31:0] pc_effective,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic        valid_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] credit;
  entry_t        head;

  // The in-flight slot is counted so a returning response always has room.
  assign credit           = count_q + CW'(inflight_q);
  assign imem_address     = fetch_pc_q;
  assign imem_access_size = 2'b00;
  assign imem_rw          = 1'b1;
  assign imem_enable      = !reset && !do_branch && (credit < DEPTH_C);
  assign accept           = imem_enable && !imem_busy;

  assign valid_out = !reset && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign pc_out    = valid_out ? head.pc : '0;
  assign insn_out  = valid_out ? head.insn : '0;

  assign push = !reset && !do_branch && inflight_q && !drop_q;
  assign pop  = valid_out && !stall && !do_branch;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    if (reset) begin
      fetch_pc_d = base_addr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = 1'b0;
    end else if (do_branch) begin
      fetch_pc_d = pc_effective;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      drop_d     = 1'b1;
    end else begin
      if (accept) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        drop_d        = 1'b0;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    fetch_pc_q    <= fetch_pc_d;
    wr_ptr_q      <= wr_ptr_d;
    rd_ptr_q      <= rd_ptr_d;
    count_q       <= count_d;
    inflight_q    <= inflight_d;
    inflight_pc_q <= inflight_pc_d;
    drop_q        <= drop_d;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_t'{pc: inflight_pc_q, insn: imem_data};
    end
  end

endmodule
